// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button levels and repeat enables in, debounced levels and event pulses out.
//   btn_in        raw asynchronous button levels, 1 = pressed
//   repeat_en     per-channel auto-repeat enable
//   level_out     debounced button level
//   press_pulse   one-cycle pulse per accepted press and per repeat
//   repeat_pulse  marks press_pulse cycles that are repeats
//   release_pulse one-cycle pulse per accepted release
//   any_press     OR of all press_pulse bits
interface button_conditioner_if #(parameter int N_CH = 4);
    logic [N_CH-1:0] btn_in, repeat_en, level_out, press_pulse, repeat_pulse, release_pulse;
    logic any_press;
    modport master(
        output btn_in, repeat_en,
        input level_out, press_pulse, repeat_pulse, release_pulse, any_press
    );
    modport slave(
        input btn_in, repeat_en,
        output level_out, press_pulse, repeat_pulse, release_pulse, any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, hold-time debouncer, press/release pulses and auto-repeat.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    button_conditioner_if slave: btn_in/repeat_en in; level_out, press/repeat/release pulses, any_press out
module button_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST  = TW'(REPEAT_PERIOD - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: illegal parameter values");
    end

    typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

    logic [N_CH-1:0] lvl_v, press_v, rep_v, rel_v;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [DW-1:0] cnt;
        logic [TW-1:0] tmr, tmr_nxt;
        logic lvl, s, accept, rise, fall, rep_hit, press_q, rep_q, rel_q;
        state_t state, state_nxt;

        assign s      = sync[SYNC_STAGES-1];
        // the level flips only after s has disagreed with it for DEBOUNCE_CYCLES edges in a row
        assign accept = (s != lvl) && (cnt == DEB_LAST);
        assign rise   = accept && !lvl;
        assign fall   = accept && lvl;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync    <= '0;
                cnt     <= '0;
                lvl     <= 1'b0;
                state   <= IDLE;
                tmr     <= '0;
                press_q <= 1'b0;
                rep_q   <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync    <= {sync[SYNC_STAGES-2:0], bus.btn_in[c]};
                cnt     <= (s == lvl || accept) ? '0 : cnt + 1'b1;
                lvl     <= lvl ^ accept;
                state   <= state_nxt;
                tmr     <= tmr_nxt;
                press_q <= rise | rep_hit;
                rep_q   <= rep_hit;
                rel_q   <= fall;
            end
        end

        // a release overrides everything, including a repeat due on the same edge
        always_comb begin
            state_nxt = state;
            tmr_nxt   = tmr;
            rep_hit   = 1'b0;
            if (fall) begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state_nxt = bus.repeat_en[c] ? DELAY : HOLD;
                        tmr_nxt   = '0;
                    end
                    HOLD: if (bus.repeat_en[c]) begin
                        state_nxt = DELAY;
                        tmr_nxt   = '0;
                    end
                    DELAY: if (!bus.repeat_en[c]) state_nxt = HOLD;
                    else if (tmr == RD_LAST) begin
                        rep_hit   = 1'b1;
                        state_nxt = REPEAT;
                        tmr_nxt   = '0;
                    end else tmr_nxt = tmr + 1'b1;
                    default: if (!bus.repeat_en[c]) state_nxt = HOLD;
                    else if (tmr == RP_LAST) begin
                        rep_hit = 1'b1;
                        tmr_nxt = '0;
                    end else tmr_nxt = tmr + 1'b1;
                endcase
            end
        end

        assign lvl_v[c]   = lvl;
        assign press_v[c] = press_q;
        assign rep_v[c]   = rep_q;
        assign rel_v[c]   = rel_q;
    end

    assign bus.level_out     = lvl_v;
    assign bus.press_pulse   = press_v;
    assign bus.repeat_pulse  = rep_v;
    assign bus.release_pulse = rel_v;
    assign bus.any_press     = |press_v;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a behavioural model checked on every cycle.
module tb_button_conditioner;
    localparam int N = 4, SYNC = 2, DEB = 4, RD = 10, RP = 3, HL = SYNC + DEB;

    logic clk = 1'b0;
    logic reset;
    int passed = 0, total = 0, ecnt = 0, base = 0;

    button_conditioner_if #(.N_CH(N)) bif();

    button_conditioner #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    // model state: sample history, accepted level, and repeat anchor time per channel
    bit [HL-1:0] hist [N];
    int anchor [N];
    int tnow = 0, d;
    bit stable;
    logic [N-1:0] m_lvl = '0, e_press = '0, e_rep = '0, e_rel = '0, armed = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                hist[c]   = '0;
                anchor[c] = 0;
            end
            m_lvl = '0; e_press = '0; e_rep = '0; e_rel = '0; armed = '0; tnow = 0;
        end else begin
            tnow++;
            e_press = '0; e_rep = '0; e_rel = '0;
            for (int c = 0; c < N; c++) begin
                hist[c] = {hist[c][HL-2:0], bif.btn_in[c]};
                // accepted when the last DEB synchronised samples all disagree with the level
                stable = 1'b1;
                for (int k = SYNC; k < HL; k++) if (hist[c][k] == m_lvl[c]) stable = 1'b0;
                if (stable && m_lvl[c]) begin
                    m_lvl[c] = 1'b0; e_rel[c] = 1'b1; armed[c] = 1'b0;
                end else if (stable) begin
                    m_lvl[c] = 1'b1; e_press[c] = 1'b1; armed[c] = bif.repeat_en[c]; anchor[c] = tnow;
                end else if (m_lvl[c]) begin
                    if (armed[c] && !bif.repeat_en[c]) armed[c] = 1'b0;
                    else if (armed[c]) begin
                        d = tnow - anchor[c];
                        if (d >= RD && (d - RD) % RP == 0) begin
                            e_press[c] = 1'b1; e_rep[c] = 1'b1;
                        end
                    end else if (bif.repeat_en[c]) begin
                        armed[c] = 1'b1; anchor[c] = tnow;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        chk("level_out", bif.level_out, m_lvl);
        chk("press_pulse", bif.press_pulse, e_press);
        chk("repeat_pulse", bif.repeat_pulse, e_rep);
        chk("release_pulse", bif.release_pulse, e_rel);
        chk("any_press", {3'b0, bif.any_press}, {3'b0, |e_press});
    end

    task automatic mark;
        base = ecnt;
    endtask

    // land on the negedge following edge e, counted from the last mark
    task automatic at(input int e);
        while (ecnt < base + 1 + e) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bif.btn_in = '0;
        bif.repeat_en = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", bif.level_out, 4'b0000);
        chk("rst_press", bif.press_pulse, 4'b0000);
        chk("rst_release", bif.release_pulse, 4'b0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        mark; bif.btn_in[0] = 1'b1;
        at(4); chk("cp_level_e4", bif.level_out, 4'b0000);
        chk("cp_press_e4", bif.press_pulse, 4'b0000);
        at(5); chk("cp_level_e5", bif.level_out, 4'b0001);
        chk("cp_press_e5", bif.press_pulse, 4'b0001);
        chk("cp_any_e5", {3'b0, bif.any_press}, 4'b0001);
        at(6); chk("cp_press_e6", bif.press_pulse, 4'b0000);
        at(10);
        mark; bif.btn_in[0] = 1'b0;
        at(4); chk("cr_release_e4", bif.release_pulse, 4'b0000);
        at(5); chk("cr_release_e5", bif.release_pulse, 4'b0001);
        chk("cr_level_e5", bif.level_out, 4'b0000);
        at(6); chk("cr_release_e6", bif.release_pulse, 4'b0000);
        at(8);

        mark; bif.btn_in[1] = 1'b1;
        at(3); bif.btn_in[1] = 1'b0;
        at(4); bif.btn_in[1] = 1'b1;
        at(7); bif.btn_in[1] = 1'b0;
        at(14); chk("bounce_level", bif.level_out, 4'b0000);
        mark; bif.btn_in[1] = 1'b1;
        at(5); chk("bounce_press", bif.press_pulse, 4'b0010);
        at(9);
        mark; bif.btn_in[1] = 1'b0;
        at(8);

        bif.repeat_en[2] = 1'b1;
        mark; bif.btn_in[2] = 1'b1;
        at(5);  chk("ar_press_P", bif.press_pulse, 4'b0100);
        chk("ar_rep_P", bif.repeat_pulse, 4'b0000);
        at(14); chk("ar_press_P9", bif.press_pulse, 4'b0000);
        at(15); chk("ar_press_P10", bif.press_pulse, 4'b0100);
        chk("ar_rep_P10", bif.repeat_pulse, 4'b0100);
        at(16); chk("ar_press_P11", bif.press_pulse, 4'b0000);
        at(18); chk("ar_rep_P13", bif.repeat_pulse, 4'b0100);
        at(40);
        mark; bif.btn_in[2] = 1'b0;
        at(5); chk("ar_rel_supp_press", bif.press_pulse, 4'b0000);
        chk("ar_rel_release", bif.release_pulse, 4'b0100);
        at(12);

        mark; bif.btn_in[2] = 1'b1;
        at(15); chk("rd_press_P10", bif.press_pulse, 4'b0100);
        at(16); bif.repeat_en[2] = 1'b0;
        at(18); chk("rd_press_P13", bif.press_pulse, 4'b0000);
        at(24); bif.repeat_en[2] = 1'b1;
        at(34); chk("rd_press_P29", bif.press_pulse, 4'b0000);
        at(35); chk("rd_press_P30", bif.press_pulse, 4'b0100);
        chk("rd_rep_P30", bif.repeat_pulse, 4'b0100);
        at(38); chk("rd_rep_P33", bif.repeat_pulse, 4'b0100);
        at(39);
        mark; bif.btn_in[2] = 1'b0;
        at(8); bif.repeat_en[2] = 1'b0;

        mark; bif.btn_in = 4'b1111;
        at(5); chk("sim_press", bif.press_pulse, 4'b1111);
        chk("sim_any", {3'b0, bif.any_press}, 4'b0001);
        at(6); chk("sim_any_e6", {3'b0, bif.any_press}, 4'b0000);
        at(8);
        mark; bif.btn_in = 4'b0000;
        at(5); chk("sim_release", bif.release_pulse, 4'b1111);
        at(8);

        bif.repeat_en[0] = 1'b1;
        mark; bif.btn_in[0] = 1'b1;
        at(15); chk("rh_rep_P10", bif.repeat_pulse, 4'b0001);
        at(17);
        #2 reset = 1'b1;
        #1 chk("rh_level", bif.level_out, 4'b0000);
        chk("rh_press", bif.press_pulse, 4'b0000);
        chk("rh_rep", bif.repeat_pulse, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mark;
        at(4); chk("rh_press_e4", bif.press_pulse, 4'b0000);
        at(5); chk("rh_press_e5", bif.press_pulse, 4'b0001);
        chk("rh_rep_e5", bif.repeat_pulse, 4'b0000);
        at(15); chk("rh_rep_e15", bif.repeat_pulse, 4'b0001);
        at(17);
        bif.repeat_en = '0;
        mark; bif.btn_in = '0;
        at(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
